// File: rtl/instruction_fetch_unit.sv
// IF-stage fetch unit: owns the PC, fetches one word per req/gnt/rvalid transaction
// and feeds the IF/ID register through a one-entry skid buffer with redirect support.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] next_instruction,
    output logic [31:0] supposed_next_address,
    output logic        fetch_valid
);

    // state   | meaning
    // ADDR    | request issued, waiting for gnt
    // WAIT    | address granted, waiting for rvalid
    // HOLD    | word parked in skid buffer until decode accepts
    // DISCARD | wrong-path response still in flight, drop it
    typedef enum logic [1:0] {
        S_ADDR    = 2'd0,
        S_WAIT    = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] sna_q;
    logic        valid_q;
    logic [31:0] skid_q;

    logic [31:0] pc_plus4;
    logic        consumed;
    logic        out_free;

    assign pc_plus4 = pc_q + 32'd4;
    assign consumed = valid_q && !stall;
    assign out_free = !valid_q || !stall;

    assign imem_req              = (state_q == S_ADDR);
    assign imem_addr             = pc_q;
    assign next_instruction      = instr_q;
    assign supposed_next_address = sna_q;
    assign fetch_valid           = valid_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_ADDR;
            pc_q    <= RESET_PC & ~32'h3;
            instr_q <= '0;
            sna_q   <= '0;
            valid_q <= 1'b0;
            skid_q  <= '0;
        end else if (redirect_valid) begin
            // Redirect flushes IF/ID and the skid buffer regardless of stall.
            pc_q    <= redirect_target & ~32'h3;
            valid_q <= 1'b0;
            instr_q <= '0;
            skid_q  <= '0;
            case (state_q)
                S_ADDR:    state_q <= imem_gnt    ? S_DISCARD : S_ADDR;
                S_WAIT:    state_q <= imem_rvalid ? S_ADDR    : S_DISCARD;
                S_HOLD:    state_q <= S_ADDR;
                S_DISCARD: state_q <= imem_rvalid ? S_ADDR    : S_DISCARD;
                default:   state_q <= S_ADDR;
            endcase
        end else begin
            if (consumed) begin
                valid_q <= 1'b0;
                instr_q <= '0;
            end
            case (state_q)
                S_ADDR: begin
                    if (imem_gnt) state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        pc_q <= pc_plus4;
                        if (out_free) begin
                            instr_q <= imem_rdata;
                            sna_q   <= pc_plus4;
                            valid_q <= 1'b1;
                            state_q <= S_ADDR;
                        end else begin
                            skid_q  <= imem_rdata;
                            state_q <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // pc already points past the parked word.
                    if (!stall) begin
                        instr_q <= skid_q;
                        sna_q   <= pc_q;
                        valid_q <= 1'b1;
                        skid_q  <= '0;
                        state_q <= S_ADDR;
                    end
                end
                S_DISCARD: begin
                    if (imem_rvalid) state_q <= S_ADDR;
                end
                default: state_q <= S_ADDR;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios, then randomized memory/stall/redirect
// traffic checked against an in-order fetch-stream scoreboard.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] next_instruction;
    logic [31:0] supposed_next_address;
    logic        fetch_valid;

    int unsigned n_tests;
    int unsigned n_fail;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .imem_req              (imem_req),
        .imem_addr             (imem_addr),
        .imem_gnt              (imem_gnt),
        .imem_rvalid           (imem_rvalid),
        .imem_rdata            (imem_rdata),
        .stall                 (stall),
        .redirect_valid        (redirect_valid),
        .redirect_target       (redirect_target),
        .next_instruction      (next_instruction),
        .supposed_next_address (supposed_next_address),
        .fetch_valid           (fetch_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drv(input logic g, input logic rv, input logic [31:0] rd,
                       input logic st, input logic rdv, input logic [31:0] tgt);
        imem_gnt        = g;
        imem_rvalid     = rv;
        imem_rdata      = rd;
        stall           = st;
        redirect_valid  = rdv;
        redirect_target = tgt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory contents: a bijection of the address, so a word identifies where it came from.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    logic [31:0] exp_pc;
    logic        outstanding;
    int unsigned lat;
    logic [31:0] out_addr;
    int unsigned n_consumed;
    logic        pv, preq;
    logic [31:0] pi, ps, paddr;
    logic        g, rv, st, rdv;
    logic [31:0] rd, tgt;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        drv(0, 0, 32'h0, 0, 0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_req", imem_req, 1);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", fetch_valid, 0);
        chk("rst_instr", next_instruction, 32'h0);
        chk("rst_sna", supposed_next_address, 32'h0);

        // Zero-wait memory, two instructions.
        drv(1, 0, 32'h0, 0, 0, 32'h0); step();
        chk("zw_req_wait", imem_req, 0);
        chk("zw_valid_early", fetch_valid, 0);
        drv(0, 1, 32'h2008_0005, 0, 0, 32'h0); step();
        chk("zw_valid1", fetch_valid, 1);
        chk("zw_instr1", next_instruction, 32'h2008_0005);
        chk("zw_sna1", supposed_next_address, 32'h4);
        chk("zw_addr2", imem_addr, 32'h4);
        chk("zw_req2", imem_req, 1);
        drv(1, 0, 32'h0, 0, 0, 32'h0); step();
        chk("zw_valid_gap", fetch_valid, 0);
        chk("zw_nop", next_instruction, 32'h0);
        drv(0, 1, 32'h2009_0003, 0, 0, 32'h0); step();
        chk("zw_instr2", next_instruction, 32'h2009_0003);
        chk("zw_sna2", supposed_next_address, 32'h8);
        chk("zw_addr3", imem_addr, 32'h8);

        // Stall with the response arriving while the output is still occupied.
        drv(1, 0, 32'h0, 1, 0, 32'h0); step();
        drv(0, 1, 32'hAAAA_AAAA, 1, 0, 32'h0); step();
        for (int i = 0; i < 3; i++) begin
            chk("st_valid", fetch_valid, 1);
            chk("st_instr", next_instruction, 32'h2009_0003);
            chk("st_sna", supposed_next_address, 32'h8);
            chk("st_req", imem_req, 0);
            drv(0, 0, 32'h0, 1, 0, 32'h0); step();
        end
        drv(0, 0, 32'h0, 0, 0, 32'h0); step();
        chk("st_release_instr", next_instruction, 32'hAAAA_AAAA);
        chk("st_release_sna", supposed_next_address, 32'hC);
        chk("st_release_valid", fetch_valid, 1);
        chk("st_release_addr", imem_addr, 32'hC);

        // Redirect while WAIT; the in-flight word must be dropped.
        drv(1, 0, 32'h0, 0, 0, 32'h0); step();
        drv(0, 0, 32'h0, 0, 1, 32'h0000_0103); step();
        chk("rd_req_discard", imem_req, 0);
        chk("rd_valid0", fetch_valid, 0);
        for (int i = 0; i < 2; i++) begin
            drv(0, 0, 32'h0, 0, 0, 32'h0); step();
            chk("rd_valid_wait", fetch_valid, 0);
        end
        drv(0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0); step();
        chk("rd_valid_drop", fetch_valid, 0);
        chk("rd_instr_drop", next_instruction, 32'h0);
        chk("rd_addr", imem_addr, 32'h100);
        chk("rd_req", imem_req, 1);
        drv(1, 0, 32'h0, 0, 0, 32'h0); step();
        drv(0, 1, 32'h1234_5678, 0, 0, 32'h0); step();
        chk("rd_instr", next_instruction, 32'h1234_5678);
        chk("rd_sna", supposed_next_address, 32'h104);

        // Redirect together with stall while a skid word is parked.
        drv(1, 0, 32'h0, 1, 0, 32'h0); step();
        drv(0, 1, 32'h0000_0055, 1, 0, 32'h0); step();
        chk("sk_req_hold", imem_req, 0);
        drv(0, 0, 32'h0, 1, 1, 32'h0000_0200); step();
        chk("sk_valid", fetch_valid, 0);
        chk("sk_instr", next_instruction, 32'h0);
        chk("sk_addr", imem_addr, 32'h200);
        chk("sk_req", imem_req, 1);
        drv(1, 0, 32'h0, 0, 0, 32'h0); step();
        chk("sk_no_skid", fetch_valid, 0);
        drv(0, 1, 32'h0000_0077, 0, 0, 32'h0); step();
        chk("sk_instr_new", next_instruction, 32'h0000_0077);
        chk("sk_sna_new", supposed_next_address, 32'h204);

        // Top-of-memory target, grant held off for 5 cycles, PC wraps.
        drv(0, 0, 32'h0, 0, 1, 32'hFFFF_FFFC); step();
        for (int i = 0; i < 5; i++) begin
            chk("wr_addr_stable", imem_addr, 32'hFFFF_FFFC);
            chk("wr_req", imem_req, 1);
            drv(0, 0, 32'h0, 0, 0, 32'h0); step();
        end
        drv(1, 0, 32'h0, 0, 0, 32'h0); step();
        drv(0, 1, 32'h0000_0099, 0, 0, 32'h0); step();
        chk("wr_instr", next_instruction, 32'h0000_0099);
        chk("wr_sna", supposed_next_address, 32'h0);
        chk("wr_addr", imem_addr, 32'h0);

        // Asynchronous reset in the middle of WAIT with a valid output held.
        drv(1, 0, 32'h0, 1, 0, 32'h0); step();
        chk("ar_pre_valid", fetch_valid, 1);
        chk("ar_pre_req", imem_req, 0);
        #2 reset = 1'b0;
        #1;
        chk("ar_valid", fetch_valid, 0);
        chk("ar_instr", next_instruction, 32'h0);
        chk("ar_sna", supposed_next_address, 32'h0);
        chk("ar_req", imem_req, 1);
        drv(0, 0, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("ar_rel_addr", imem_addr, 32'h0);
        chk("ar_rel_req", imem_req, 1);

        // Randomized traffic against an in-order fetch-stream scoreboard.
        exp_pc      = 32'h0;
        outstanding = 1'b0;
        lat         = 0;
        out_addr    = 32'h0;
        n_consumed  = 0;
        for (int c = 0; c < 4000; c++) begin
            chk("inv_align", {30'h0, imem_addr[1:0]}, 32'h0);
            if (outstanding) chk("inv_one_outstanding", imem_req, 0);

            g   = ($urandom_range(0, 2) != 0);
            rv  = outstanding && (lat == 0);
            rd  = rv ? mem_word(out_addr) : $urandom;
            st  = ($urandom_range(0, 2) == 0);
            rdv = ($urandom_range(0, 15) == 0);
            tgt = $urandom;
            drv(g, rv, rd, st, rdv, tgt);
            pv = fetch_valid; pi = next_instruction; ps = supposed_next_address;
            preq = imem_req; paddr = imem_addr;
            step();

            if (rv) outstanding = 1'b0;
            else if (outstanding) lat--;
            if (preq && g) begin
                outstanding = 1'b1;
                out_addr    = paddr;
                lat         = $urandom_range(0, 3);
            end

            if (rdv) begin
                exp_pc = tgt & ~32'h3;
                chk("rnd_redirect_flush", fetch_valid, 0);
            end else if (pv && !st) begin
                chk("rnd_instr", pi, mem_word(exp_pc));
                chk("rnd_sna", ps, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                n_consumed++;
            end else if (pv && st) begin
                chk("rnd_hold_valid", fetch_valid, 1);
                chk("rnd_hold_instr", next_instruction, pi);
                chk("rnd_hold_sna", supposed_next_address, ps);
            end
            if (preq && !g && !rdv) begin
                chk("rnd_req_held", imem_req, 1);
                chk("rnd_addr_stable", imem_addr, paddr);
            end
        end
        chk("rnd_progress", (n_consumed > 200) ? 32'd1 : 32'd0, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- IF-stage producer for the IF/ID pipeline register. Owns the PC and fetches one instruction per transaction from instruction memory.
- Memory interface is req/gnt for the address and rvalid for the data, with one transaction outstanding at most.
- Presents next_instruction and supposed_next_address (PC+4) to IF/ID.
- Honours decode stall through a 1-entry skid buffer, and branch/jump redirect with wrong-path discard.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset.
- imem_req  out  1  address request valid.
- imem_addr  out  32  fetch address; always equals pc.
- imem_gnt  in  1  memory accepted address (valid only with imem_req).
- imem_rvalid  in  1  read data valid, one cycle, exactly once per granted request.
- imem_rdata  in  32  instruction word, valid when imem_rvalid.
- stall  in  1  decode cannot accept; output register must hold.
- redirect_valid  in  1  branch/jump taken, one-cycle pulse.
- redirect_target  in  32  new PC; bits [1:0] ignored (forced 00).
- next_instruction  out  32  fetched instruction to IF/ID.
- supposed_next_address  out  32  address of that instruction + 4.
- fetch_valid  out  1  next_instruction/supposed_next_address hold a valid instruction.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_PC, state=ADDR.
  - next_instruction=0, supposed_next_address=0, fetch_valid=0.
  - Skid buffer empty (skid_instr=0).
  - Any outstanding transaction is abandoned; memory shares the same reset.
- imem_req = (state==ADDR), combinational. It is asserted in the first cycle after reset release.
- Output register "consumed" at a posedge = fetch_valid && !stall.
- Output register "free" = !fetch_valid || !stall.
- State transitions, evaluated at posedge, with redirect handled first:
  - ADDR:
    - imem_gnt=1 -> WAIT.
    - Otherwise stay; pc and imem_addr stay stable while waiting.
  - WAIT, imem_rvalid=1:
    - If the output register is free: next_instruction<=imem_rdata, supposed_next_address<=pc+4, fetch_valid<=1, pc<=pc+4 -> ADDR.
    - Else: skid_instr<=imem_rdata, pc<=pc+4 -> HOLD. Memory data is never dropped.
  - HOLD:
    - stall=0 -> next_instruction<=skid_instr, supposed_next_address<=pc (already advanced), fetch_valid<=1 -> ADDR.
    - Otherwise stay. No request is issued in HOLD.
  - DISCARD: imem_req=0; on imem_rvalid=1 the data is dropped -> ADDR.
- When no new instruction is loaded and the output is consumed: fetch_valid<=0 and next_instruction<=0 (NOP). supposed_next_address holds its value.
- Redirect (redirect_valid=1) overrides stall and all state:
  - pc<=redirect_target & ~3.
  - fetch_valid<=0, next_instruction<=0; skid buffer cleared.
  - Next state by current state:
    - ADDR without gnt -> ADDR (new address issued next cycle).
    - ADDR with gnt -> DISCARD.
    - WAIT without rvalid -> DISCARD.
    - WAIT with rvalid -> ADDR (data dropped).
    - HOLD -> ADDR.
    - DISCARD without rvalid -> DISCARD (pc updated).
    - DISCARD with rvalid -> ADDR.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC + 4 = 0 with no flag.
- Throughput:
  - Zero-wait memory (gnt in ADDR cycle, rvalid the following cycle) gives 1 instruction per 2 cycles.
  - First fetch_valid rises 2 cycles after reset release.
- Invariants:
  - Never more than 1 outstanding request.
  - pc[1:0] always 00.
  - imem_addr is constant from req assertion until gnt.

Test Plan:
- Reset then zero-wait memory returning 0x2008_0005, 0x2009_0003 -> first fetch_valid=1 with next_instruction=0x2008_0005, supposed_next_address=0x4. Second instruction shows supposed_next_address=0x8; imem_addr sequence 0x0, 0x4, 0x8.
- stall held 4 cycles while fetch_valid=1 and rvalid arrives with 0xAAAA_AAAA -> outputs frozen, state HOLD, imem_req=0. One cycle after stall drops, next_instruction=0xAAAA_AAAA.
- redirect_valid with target 0x0000_0103 while in WAIT, rvalid arriving 3 cycles later with 0xDEAD_BEEF -> 0xDEAD_BEEF never appears and fetch_valid=0 meanwhile. Next imem_addr=0x100; subsequent supposed_next_address=0x104.
- redirect_valid in the same cycle as stall=1 with output valid and HOLD pending -> skid data dropped, fetch_valid=0 next cycle, next fetch at target.
- gnt delayed 5 cycles with redirect_target=0xFFFF_FFFC -> imem_addr stable at 0xFFFF_FFFC; after data, supposed_next_address=0x0000_0000.
- reset asserted mid-WAIT -> all outputs 0 immediately (asynchronous). After release, imem_addr=RESET_PC with imem_req=1.
